// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - serialises inst/data cache requests onto a single-beat AXI master
module cache_axi_arbiter #(
   parameter int PRIO_DATA = 1
) (
   input  logic        clk,
   input  logic        resetn,
   // instruction cache port
   input  logic        inst_cache_req,
   input  logic [31:0] inst_cache_addr,
   input  logic        inst_cache_wr,
   input  logic [1:0]  inst_cache_size,
   input  logic [31:0] inst_cache_wdata,
   output logic [31:0] inst_cache_rdata,
   output logic        inst_cache_dok,
   // data cache port
   input  logic        data_cache_req,
   input  logic [31:0] data_cache_addr,
   input  logic        data_cache_wr,
   input  logic [1:0]  data_cache_size,
   input  logic [31:0] data_cache_wdata,
   output logic [31:0] data_cache_rdata,
   output logic        data_cache_dok,
   output logic        stall_by_arbitrater,
   // AXI read address / data
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   // AXI write address / data / response
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP,
      RESP
   } state_e;

   state_e      state_q, state_d;
   logic        owner_q, owner_d;        // 1 = data port owns the transaction
   logic        tie_q, tie_d;            // grant was decided by the round-robin pointer
   logic        rr_q, rr_d;              // 1 = data port wins the next tie
   logic [31:0] addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic        grant_data;
   logic        tie;

   // state and datapath registers; reset abandons any in-flight AXI transfer
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         tie_q     <= 1'b0;
         rr_q      <= 1'b1;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         size_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         tie_q     <= tie_d;
         rr_q      <= rr_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign tie        = inst_cache_req & data_cache_req;
   assign grant_data = data_cache_req & (~inst_cache_req | (PRIO_DATA != 0) | rr_q);

   // next-state and register updates; AXI inputs only steer state, never outputs
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      tie_d     = tie_q;
      rr_d      = rr_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      size_d    = size_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            if (inst_cache_req | data_cache_req) begin
               owner_d   = grant_data;
               tie_d     = tie;
               addr_d    = grant_data ? data_cache_addr  : inst_cache_addr;
               wr_d      = grant_data ? data_cache_wr    : inst_cache_wr;
               size_d    = grant_data ? data_cache_size  : inst_cache_size;
               wdata_d   = grant_data ? data_cache_wdata : inst_cache_wdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (grant_data ? data_cache_wr : inst_cache_wr) ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (rvalid) begin
               rdata_d = rdata;
               state_d = RESP;
            end
         end
         WR_REQ: begin
            aw_done_d = aw_done_q | awready;
            w_done_d  = w_done_q | wready;
            if (aw_done_d & w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (bvalid) state_d = RESP;
         end
         RESP: begin
            if (tie_q && (PRIO_DATA == 0)) rr_d = ~rr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // byte-lane strobes from the latched size and low address bits
   always_comb begin
      wstrb = 4'b0000;
      case (size_q)
         2'b00:   wstrb = 4'b0001 << addr_q[1:0];
         2'b01:   wstrb = 4'b0011 << addr_q[1:0];
         2'b10:   wstrb = 4'b1111;
         default: wstrb = 4'b0000;
      endcase
   end

   assign araddr  = addr_q;
   assign arsize  = {1'b0, size_q};
   assign arvalid = (state_q == RD_ADDR);
   assign rready  = (state_q == RD_DATA);
   assign awaddr  = addr_q;
   assign awsize  = {1'b0, size_q};
   assign awvalid = (state_q == WR_REQ) & ~aw_done_q;
   assign wdata   = wdata_q;
   assign wvalid  = (state_q == WR_REQ) & ~w_done_q;
   assign bready  = (state_q == WR_RESP);

   assign inst_cache_dok   = (state_q == RESP) & ~owner_q;
   assign data_cache_dok   = (state_q == RESP) & owner_q;
   assign inst_cache_rdata = rdata_q;
   assign data_cache_rdata = rdata_q;

   assign stall_by_arbitrater = (inst_cache_req & ~inst_cache_dok) |
                                (data_cache_req & ~data_cache_dok);

   logic unused_wr;
   assign unused_wr = wr_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - directed self-checking bench for cache_axi_arbiter
module tb_cache_axi_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req, data_req;
   logic [31:0] inst_addr, data_addr;
   logic        inst_wr, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_wdata, data_wdata;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;

   // priority instance outputs
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_dok, data_dok, stall;
   logic [31:0] araddr, awaddr, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic [3:0]  wstrb;

   // round-robin instance outputs
   logic [31:0] r_inst_rdata, r_data_rdata;
   logic        r_inst_dok, r_data_dok, r_stall;
   logic [31:0] r_araddr, r_awaddr, r_wdata;
   logic [2:0]  r_arsize, r_awsize;
   logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
   logic [3:0]  r_wstrb;

   int checks = 0;
   int errors = 0;

   cache_axi_arbiter #(.PRIO_DATA(1)) u_dut (
      .clk(clk), .resetn(resetn),
      .inst_cache_req(inst_req), .inst_cache_addr(inst_addr), .inst_cache_wr(inst_wr),
      .inst_cache_size(inst_size), .inst_cache_wdata(inst_wdata),
      .inst_cache_rdata(inst_rdata), .inst_cache_dok(inst_dok),
      .data_cache_req(data_req), .data_cache_addr(data_addr), .data_cache_wr(data_wr),
      .data_cache_size(data_size), .data_cache_wdata(data_wdata),
      .data_cache_rdata(data_rdata), .data_cache_dok(data_dok),
      .stall_by_arbitrater(stall),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   cache_axi_arbiter #(.PRIO_DATA(0)) u_rr (
      .clk(clk), .resetn(resetn),
      .inst_cache_req(inst_req), .inst_cache_addr(inst_addr), .inst_cache_wr(inst_wr),
      .inst_cache_size(inst_size), .inst_cache_wdata(inst_wdata),
      .inst_cache_rdata(r_inst_rdata), .inst_cache_dok(r_inst_dok),
      .data_cache_req(data_req), .data_cache_addr(data_addr), .data_cache_wr(data_wr),
      .data_cache_size(data_size), .data_cache_wdata(data_wdata),
      .data_cache_rdata(r_data_rdata), .data_cache_dok(r_data_dok),
      .stall_by_arbitrater(r_stall),
      .araddr(r_araddr), .arsize(r_arsize), .arvalid(r_arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(r_rready),
      .awaddr(r_awaddr), .awsize(r_awsize), .awvalid(r_awvalid), .awready(awready),
      .wdata(r_wdata), .wstrb(r_wstrb), .wvalid(r_wvalid), .wready(wready),
      .bvalid(bvalid), .bready(r_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // directed sequence; cycle numbers count from the IDLE cycle that sees the request
   initial begin
      resetn = 1'b1;
      inst_req = 0; data_req = 0;
      inst_addr = '0; data_addr = '0; inst_wr = 0; data_wr = 0;
      inst_size = 2'b10; data_size = 2'b10; inst_wdata = '0; data_wdata = '0;
      arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1; rdata = '0;
      tick(); tick();
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_doks", {inst_dok, data_dok}, 0);
      chk("rst_rdata", inst_rdata, 0);
      resetn = 1'b0;
      tick();

      // single instruction read, zero-wait slave
      inst_req = 1; inst_addr = 32'hBFC00000; inst_wr = 0; inst_size = 2'b10;
      rdata = 32'h3C08BFAF;
      #1 chk("rd_stall_c0", stall, 1);
      tick();
      chk("rd_arvalid_c1", arvalid, 1);
      chk("rd_araddr", araddr, 32'hBFC00000);
      chk("rd_arsize", arsize, 3'b010);
      chk("rd_stall_c1", stall, 1);
      tick();
      chk("rd_rready_c2", rready, 1);
      chk("rd_stall_c2", stall, 1);
      tick();
      chk("rd_idok_c3", inst_dok, 1);
      chk("rd_ddok_c3", data_dok, 0);
      chk("rd_rdata", inst_rdata, 32'h3C08BFAF);
      chk("rd_stall_c3", stall, 0);
      inst_req = 0;
      tick();
      chk("rd_idok_c4", inst_dok, 0);

      // data byte write, awready late by two cycles
      data_req = 1; data_addr = 32'h80000003; data_wr = 1; data_size = 2'b00;
      data_wdata = 32'hAB000000; awready = 0;
      #1 tick();
      chk("bw_awvalid_c1", awvalid, 1);
      chk("bw_wvalid_c1", wvalid, 1);
      chk("bw_wstrb", wstrb, 4'b1000);
      chk("bw_awsize", awsize, 3'b000);
      chk("bw_awaddr", awaddr, 32'h80000003);
      chk("bw_wdata", wdata, 32'hAB000000);
      tick();
      chk("bw_wvalid_c2", wvalid, 0);
      chk("bw_awvalid_c2", awvalid, 1);
      tick();
      chk("bw_awvalid_c3", awvalid, 1);
      awready = 1;
      tick();
      chk("bw_awvalid_c4", awvalid, 0);
      chk("bw_bready_c4", bready, 1);
      chk("bw_ddok_c4", data_dok, 0);
      tick();
      chk("bw_ddok_c5", data_dok, 1);
      chk("bw_idok_c5", inst_dok, 0);
      chk("bw_rdata_kept", data_rdata, 32'h3C08BFAF);
      data_req = 0;
      tick();
      chk("bw_ddok_c6", data_dok, 0);

      // simultaneous reads, data priority
      rdata = 32'h11111111;
      inst_req = 1; inst_addr = 32'h00001000; inst_wr = 0; inst_size = 2'b10;
      data_req = 1; data_addr = 32'h00002000; data_wr = 0; data_size = 2'b10;
      #1 tick();
      chk("pr_araddr_first", araddr, 32'h00002000);
      tick(); tick();
      chk("pr_ddok_c3", data_dok, 1);
      chk("pr_idok_c3", inst_dok, 0);
      chk("pr_stall_c3", stall, 1);
      data_req = 0;
      tick();
      chk("pr_arvalid_c4", arvalid, 0);
      chk("pr_stall_c4", stall, 1);
      tick();
      chk("pr_arvalid_c5", arvalid, 1);
      chk("pr_araddr_second", araddr, 32'h00001000);
      tick(); tick();
      chk("pr_idok_c7", inst_dok, 1);
      chk("pr_rdata_c7", inst_rdata, 32'h11111111);
      inst_req = 0;
      tick();

      // reset while waiting for read data
      rvalid = 0;
      inst_req = 1; inst_addr = 32'h00000040;
      #1 tick(); tick(); tick();
      chk("rs_rready_wait", rready, 1);
      resetn = 1'b1;
      #1;
      chk("rs_arvalid", arvalid, 0);
      chk("rs_rready", rready, 0);
      chk("rs_idok", inst_dok, 0);
      chk("rs_rdata", inst_rdata, 0);
      inst_req = 0;
      tick();
      resetn = 1'b0; rvalid = 1; rdata = 32'hDEADBEEF;
      tick();
      inst_req = 1; inst_addr = 32'h00000044;
      #1 tick();
      chk("rs2_arvalid", arvalid, 1);
      chk("rs2_araddr", araddr, 32'h00000044);
      tick(); tick();
      chk("rs2_idok", inst_dok, 1);
      chk("rs2_rdata", inst_rdata, 32'hDEADBEEF);
      inst_req = 0;
      tick();

      // round-robin instance with both ports requesting back to back
      rdata = 32'h22222222;
      inst_req = 1; inst_addr = 32'h00001000;
      data_req = 1; data_addr = 32'h00002000;
      #1 tick();
      chk("rr_araddr_1", r_araddr, 32'h00002000);
      tick(); tick();
      chk("rr_ddok_1", r_data_dok, 1);
      chk("rr_idok_1", r_inst_dok, 0);
      tick(); tick();
      chk("rr_arvalid_2", r_arvalid, 1);
      chk("rr_araddr_2", r_araddr, 32'h00001000);
      tick(); tick();
      chk("rr_idok_2", r_inst_dok, 1);
      chk("rr_ddok_2", r_data_dok, 0);
      tick(); tick();
      chk("rr_araddr_3", r_araddr, 32'h00002000);
      tick(); tick();
      chk("rr_ddok_3", r_data_dok, 1);
      inst_req = 0; data_req = 0;
      tick();

      // half-word and illegal-size write strobes
      inst_req = 1; inst_wr = 1; inst_size = 2'b01; inst_addr = 32'h00000002;
      inst_wdata = 32'hBEEF0000;
      #1 tick();
      chk("hw2_wstrb", wstrb, 4'b1100);
      chk("hw2_awsize", awsize, 3'b001);
      tick(); tick();
      chk("hw2_idok", inst_dok, 1);
      inst_req = 0;
      tick();
      inst_req = 1; inst_addr = 32'h00000000; inst_wdata = 32'h0000BEEF;
      #1 tick();
      chk("hw0_wstrb", wstrb, 4'b0011);
      tick(); tick();
      chk("hw0_idok", inst_dok, 1);
      inst_req = 0;
      tick();
      inst_req = 1; inst_size = 2'b11; inst_addr = 32'h00000001;
      #1 tick();
      chk("ill_wstrb", wstrb, 4'b0000);
      tick(); tick();
      chk("ill_idok", inst_dok, 1);
      inst_req = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
